// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: strips E0/F0/E1 prefixes, queues key events in a
// small FWFT FIFO and tracks the shift/ctrl/alt modifier state.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic [7:0] scancode,
  input  logic       scan_ready,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_break,
  output logic       event_valid,
  input  logic       event_ack,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       overflow
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = FIFO_DEPTH[ADDR_W:0];

  state_t      state, state_nx;
  logic [2:0]  pcnt, pcnt_nx;
  logic        push;
  logic [7:0]  push_code;
  logic        push_ext, push_brk;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state <= IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nx;
      pcnt  <= pcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pcnt_nx   = pcnt;
    push      = 1'b0;
    push_code = scancode;
    push_ext  = 1'b0;
    push_brk  = 1'b0;
    if (scan_ready) begin
      unique case (state)
        IDLE: begin
          case (scancode)
            8'hE0: state_nx = EXT;
            8'hF0: state_nx = BRK;
            8'hE1: begin
              state_nx = PAUSE;
              pcnt_nx  = '0;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: push = 1'b1;
          endcase
        end
        EXT: begin
          case (scancode)
            8'hF0: state_nx = EXT_BRK;
            8'hE0: state_nx = EXT;
            8'h12, 8'h59: state_nx = IDLE;
            default: begin
              push     = 1'b1;
              push_ext = 1'b1;
              state_nx = IDLE;
            end
          endcase
        end
        BRK: begin
          push     = 1'b1;
          push_brk = 1'b1;
          state_nx = IDLE;
        end
        EXT_BRK: begin
          state_nx = IDLE;
          if (scancode != 8'h12 && scancode != 8'h59) begin
            push     = 1'b1;
            push_ext = 1'b1;
            push_brk = 1'b1;
          end
        end
        PAUSE: begin
          if (pcnt == 3'd6) begin
            push      = 1'b1;
            push_code = 8'hE1;
            state_nx  = IDLE;
          end else begin
            pcnt_nx = pcnt + 3'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic lshift, rshift, lctrl, rctrl, lalt, ralt;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      {lshift, rshift, lctrl, rctrl, lalt, ralt} <= '0;
    end else if (push) begin
      case ({push_ext, push_code})
        9'h012: lshift <= ~push_brk;
        9'h059: rshift <= ~push_brk;
        9'h014: lctrl  <= ~push_brk;
        9'h114: rctrl  <= ~push_brk;
        9'h011: lalt   <= ~push_brk;
        9'h111: ralt   <= ~push_brk;
        default: ;
      endcase
    end
  end

  assign mod_shift = lshift | rshift;
  assign mod_ctrl  = lctrl | rctrl;
  assign mod_alt   = lalt | ralt;

  logic [9:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nx;
  logic [ADDR_W:0]   count, count_nx;
  logic              full, pop, wr_en;
  logic [9:0]        push_data, head_nx;

  assign full      = (count == FULL_CNT);
  assign pop       = event_ack && event_valid;
  assign wr_en     = push && (!full || pop);
  assign push_data = {push_code, push_ext, push_brk};
  assign rd_nx     = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    count_nx = count;
    unique case ({wr_en, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  // Registered head: when the next head is the slot being written this edge,
  // take it from the push data since the memory write has not landed yet.
  assign head_nx = (wr_en && rd_nx == wr_ptr) ? push_data : mem[rd_nx];

  always_ff @(posedge CLK50MHZ) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      event_code  <= '0;
      event_ext   <= 1'b0;
      event_break <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nx;
      count  <= count_nx;
      if (push && full && !pop) overflow <= 1'b1;
      if (count_nx != '0) {event_code, event_ext, event_break} <= head_nx;
    end
  end

  assign event_valid = (count != '0);

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: a prefix-tracking event model with a
// queue-based FIFO is compared every cycle, plus hand-computed literal checks.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, ready, ack;
  logic [7:0] sc;
  logic [7:0] event_code;
  logic       event_ext, event_break, event_valid;
  logic       mod_shift, mod_ctrl, mod_alt, overflow;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .CLK50MHZ   (clk),
    .RST        (rst),
    .scancode   (sc),
    .scan_ready (ready),
    .event_code (event_code),
    .event_ext  (event_ext),
    .event_break(event_break),
    .event_valid(event_valid),
    .event_ack  (ack),
    .mod_shift  (mod_shift),
    .mod_ctrl   (mod_ctrl),
    .mod_alt    (mod_alt),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: event = {code, ext, brk}; held[] indexed by {ext, code}
  logic [9:0] mq[$];
  logic [9:0] m_last;
  logic [9:0] ev;
  bit         m_ovf, m_ext, m_brk, m_ok, have, do_pop;
  bit         held[512];
  int         m_pause;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_last = '0;
      m_ovf  = 0;
      foreach (held[i]) held[i] = 0;
      m_ext   = 0;
      m_brk   = 0;
      m_pause = 0;
      m_ok    = 1;
    end else begin
      have   = 0;
      ev     = '0;
      do_pop = ack && (mq.size() > 0);
      if (ready) begin
        if (m_pause > 0) begin
          m_pause--;
          if (m_pause == 0) begin
            have = 1;
            ev   = {8'hE1, 2'b00};
          end
        end else if (m_brk) begin
          if (!(m_ext && (sc == 8'h12 || sc == 8'h59))) begin
            have = 1;
            ev   = {sc, m_ext, 1'b1};
          end
          m_ext = 0;
          m_brk = 0;
        end else if (m_ext) begin
          if (sc == 8'hF0) m_brk = 1;
          else if (sc != 8'hE0) begin
            if (sc != 8'h12 && sc != 8'h59) begin
              have = 1;
              ev   = {sc, 2'b10};
            end
            m_ext = 0;
          end
        end else begin
          case (sc)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            8'hE1: m_pause = 7;
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: begin
              have = 1;
              ev   = {sc, 2'b00};
            end
          endcase
        end
      end
      if (have) held[{ev[1], ev[9:2]}] = !ev[0];
      if (do_pop) void'(mq.pop_front());
      if (have) begin
        if (mq.size() >= DEPTH) m_ovf = 1;
        else mq.push_back(ev);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid", event_valid, mq.size() > 0);
      chk("code", event_code, m_last[9:2]);
      chk("ext", event_ext, m_last[1]);
      chk("brk", event_break, m_last[0]);
      chk("shift", mod_shift, held[{1'b0, 8'h12}] | held[{1'b0, 8'h59}]);
      chk("ctrl", mod_ctrl, held[{1'b0, 8'h14}] | held[{1'b1, 8'h14}]);
      chk("alt", mod_alt, held[{1'b0, 8'h11}] | held[{1'b1, 8'h11}]);
      chk("overflow", overflow, m_ovf);
    end
  end

  int npop = 0;
  always @(posedge clk) if (!rst && event_valid && ack) npop++;

  task automatic sb(input logic [7:0] b);
    sc    = b;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic pop1();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; ack = 1'b0; sc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 8'h00);
    chk("rst_mods", {mod_shift, mod_ctrl, mod_alt, overflow}, 4'b0000);

    // make / break with ack held high
    ack = 1'b1;
    sb(8'h1C);
    chk("make_valid", event_valid, 1);
    chk("make_ev", {event_code, event_ext, event_break}, {8'h1C, 2'b00});
    @(negedge clk);
    chk("popped_valid", event_valid, 0);
    chk("hold_code", event_code, 8'h1C);
    sb(8'hF0); sb(8'h1C);
    chk("break_ev", {event_valid, event_code, event_ext, event_break}, {1'b1, 8'h1C, 2'b01});
    @(negedge clk);

    // extended make / break, then print-screen
    sb(8'hE0); sb(8'h75);
    chk("ext_make", {event_code, event_ext, event_break}, {8'h75, 2'b10});
    sb(8'hE0); sb(8'hF0); sb(8'h75);
    chk("ext_break", {event_code, event_ext, event_break}, {8'h75, 2'b11});
    repeat (2) @(negedge clk);
    npop = 0;
    sb(8'hE0); sb(8'h12); sb(8'hE0); sb(8'h7C);
    sb(8'hE0); sb(8'hF0); sb(8'h7C); sb(8'hE0); sb(8'hF0); sb(8'h12);
    repeat (2) @(negedge clk);
    chk("prtsc_events", npop, 2);
    chk("prtsc_last", {event_code, event_ext, event_break}, {8'h7C, 2'b11});

    // modifiers
    sb(8'h12);               chk("shift_on", mod_shift, 1);
    sb(8'h14);               chk("ctrl_on", mod_ctrl, 1);
    sb(8'hE0); sb(8'h11);    chk("alt_on", mod_alt, 1);
    sb(8'hF0); sb(8'h12);    chk("shift_off", mod_shift, 0);
    sb(8'h12);
    sb(8'hE0); sb(8'h12);    chk("fake_make", mod_shift, 1);
    sb(8'hE0); sb(8'hF0); sb(8'h12);
    chk("fake_break", mod_shift, 1);
    sb(8'hF0); sb(8'h12);
    sb(8'h59);               chk("rshift_on", mod_shift, 1);
    sb(8'hF0); sb(8'h59);    chk("rshift_off", mod_shift, 0);
    sb(8'hF0); sb(8'h14);
    sb(8'hE0); sb(8'hF0); sb(8'h11);
    chk("mods_clear", {mod_ctrl, mod_alt}, 2'b00);
    repeat (2) @(negedge clk);

    // overflow with ack low
    ack = 1'b0;
    for (int unsigned i = 1; i <= 5; i++) begin
      sb(8'(i));
      if (i == 4) chk("full_no_ovf", overflow, 0);
    end
    chk("ovf_valid", event_valid, 1);
    chk("ovf_set", overflow, 1);
    for (int unsigned i = 1; i <= 4; i++) begin
      chk("drain_code", event_code, 8'(i));
      pop1();
    end
    chk("drain_empty", event_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // full + simultaneous push/pop
    do_reset();
    chk("rst2", {event_valid, event_code, overflow}, 10'h000);
    for (int unsigned i = 0; i < 4; i++) sb(8'h21 + 8'(i));
    ack = 1'b1;
    sb(8'h25);
    ack = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("pp_code", event_code, 8'h22 + 8'(i));
      pop1();
    end
    chk("pp_empty", event_valid, 0);

    // pause sequence
    do_reset();
    sb(8'hE1); sb(8'h14); sb(8'h77); sb(8'hE1); sb(8'hF0); sb(8'h14); sb(8'hF0);
    chk("pause_mid", event_valid, 0);
    sb(8'h77);
    chk("pause_ev", {event_valid, event_code, event_ext, event_break}, {1'b1, 8'hE1, 2'b00});
    chk("pause_mods", {mod_shift, mod_ctrl, mod_alt}, 3'b000);
    pop1();
    chk("pause_empty", event_valid, 0);

    // reset mid-prefix
    sb(8'h12);
    sb(8'hE0); sb(8'hF0);
    do_reset();
    chk("rst_mid", {event_valid, mod_shift, event_code}, 10'h000);
    sb(8'h1C);
    chk("after_rst", {event_valid, event_code, event_ext, event_break}, {1'b1, 8'h1C, 2'b00});
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes the raw scancode byte stream (set 2) and its one-cycle strobe, and strips the E0/F0/E1 prefixes.
- Emits one key event per complete sequence (code, extended, break) into a small first-word-fall-through event FIFO with a valid/ack handshake.
- Tracks the shift/ctrl/alt modifier state for consumers such as a keyboard-to-ASCII or display block.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
- CLK50MHZ  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- scancode  input  8  received byte; valid only while scan_ready is high.
- scan_ready  input  1  one-cycle strobe per received byte; may assert on consecutive cycles.
- event_code  output  8  head-of-FIFO key code with the prefix removed.
- event_ext  output  1  head event was E0-prefixed.
- event_break  output  1  head event is a release (F0).
- event_valid  output  1  FIFO not empty; event_* outputs are meaningful.
- event_ack  input  1  consumer pops the head; ignored while event_valid is low.
- mod_shift  output  1  left shift (12) or right shift (59) currently held.
- mod_ctrl  output  1  left ctrl (14) or right ctrl (E0 14) held.
- mod_alt  output  1  left alt (11) or right alt (E0 11) held.
- overflow  output  1  sticky: at least one event was dropped because the FIFO was full.

Behaviour:
- Reset (RST high at a clock edge):
  - FSM goes to IDLE, pause counter = 0, FIFO emptied.
  - event_valid = 0, event_code = 8'h00, event_ext = 0, event_break = 0.
  - All mod_* = 0, overflow = 0.
  - Reset mid-sequence discards any partial prefix; no event is produced for it.
- Bytes are processed only on cycles where scan_ready is high. All other cycles leave the FSM unchanged.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, counter = 0.
  - AA, FA, FE, EE, 00, FF -> dropped, stay IDLE.
  - Any other byte -> push make event {code, ext=0, brk=0}, stay IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - 12 or 59 (fake shift) -> drop, go IDLE.
  - Any other byte -> push {code, ext=1, brk=0}, go IDLE.
- BRK: any byte -> push {code, 0, 1}, go IDLE.
- EXT_BRK:
  - 12 or 59 -> drop, go IDLE.
  - Any other byte -> push {code, 1, 1}, go IDLE.
- PAUSE:
  - Counts the 7 bytes that follow E1. Their values are ignored and no state other than the counter changes.
  - On the 7th byte -> push {8'hE1, 0, 0}, go IDLE.
- Latency: a push occurs on the edge that samples the final byte's scan_ready. event_valid rises on the next cycle; the event_* outputs are registered.
- Modifiers:
  - Updated on the same edge as the push, from the decoded event: make sets the flag, break clears it.
  - Updated even if the push is dropped for overflow.
  - Extended 12/59 never touch mod_shift.
  - Left and right sources are held separately; each output is the OR of its two sources.
- FIFO:
  - First-word fall-through: head contents are on event_* whenever event_valid = 1.
  - Pop happens when event_ack && event_valid.
  - Push and pop in the same cycle:
    - Occupancy is unchanged.
    - Allowed when full: the pop frees the slot and the push succeeds, with no overflow.
    - When empty, the pushed event appears on the next cycle with event_valid = 1.
  - Push when full with no pop: the event is dropped, the FIFO is unchanged, and overflow is set and held until RST.
  - Read and write pointers are ADDR_W bits and wrap naturally; occupancy is tracked with an ADDR_W+1 bit counter.
- When the FIFO is empty, event_* hold their last value and event_valid = 0.

Test Plan:
- Bytes 1C, then F0 1C, with event_ack tied high -> two events {1C,0,0} then {1C,0,1}; each event_valid rises 1 cycle after the final strobe.
- E0 75, then E0 F0 75 -> events {75,1,0} and {75,1,1}. Print-screen sequence E0 12 E0 7C E0 F0 7C E0 F0 12 -> exactly {7C,1,0},{7C,1,1}.
- 12, 14, E0 11 -> mod_shift, mod_ctrl, mod_alt = 1 in turn. Then F0 12 -> mod_shift = 0. E0 12 sent while shift is held -> mod_shift unchanged.
- With event_ack low, send 5 makes (01..05) -> event_valid = 1 and overflow = 1 after the 5th. Popping then yields exactly 01,02,03,04, after which event_valid = 0.
- FIFO full, then a scan_ready strobe in the same cycle as event_ack -> overflow stays 0 and the new event lands at the tail.
- E1 14 77 E1 F0 14 F0 77 -> one event {E1,0,0} and no modifier changes. Separately, E0 F0 then RST, then 1C -> event {1C,0,0} (prefix discarded), with the FIFO and mod_* cleared by the reset.
